alu_mul_sequencer: RTL

//  Multi-cycle unsigned shift-add multiplier controller. It time-shares the 16-bit ALU to build a
//  2*WIDTH-bit product, one ALU ADD per cycle. It sits beside the EX stage.
//  The pipeline issues MUL operands through a valid/ready handshake and stalls on in_ready=0.
//  The block owns the ALU operand/op inputs only while busy=1; the EX mux selects on busy.

---
 rtl/alu_mul_sequencer.sv | 93 +++++++++
 1 files changed

// File: rtl/alu_mul_sequencer.sv
// Shift-add unsigned multiplier controller that time-shares the EX-stage ALU,
// issuing one ADD per cycle for WIDTH cycles to build a 2*WIDTH-bit product.
module alu_mul_sequencer #(
  parameter int          WIDTH      = 16,
  parameter int          CNT_W      = 5,
  parameter logic [3:0]  ALU_OP_ADD = 4'h0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy,
  output logic [WIDTH-1:0]     alu_a,
  output logic [WIDTH-1:0]     alu_b,
  output logic [3:0]           alu_op,
  input  logic [WIDTH-1:0]     alu_result,
  input  logic                 alu_cout
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      mcand_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      mcand_q  <= mcand_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    mcand_d   = mcand_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    product   = '0;
    alu_a     = '0;
    alu_b     = '0;
    alu_op    = ALU_OP_ADD;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          mcand_d  = in_a;
          acc_lo_d = in_b;
          acc_hi_d = '0;
          cnt_d    = '0;
          state_d  = CALC;
        end
      end
      CALC: begin
        busy  = 1'b1;
        alu_a = acc_hi_q;
        alu_b = acc_lo_q[0] ? mcand_q : '0;
        // ALU outputs are only consumed here, so X outside CALC never reaches state.
        {acc_hi_d, acc_lo_d} = {alu_cout, alu_result, acc_lo_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH-1))
          state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        product   = {acc_hi_q, acc_lo_q};
        if (out_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
